// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment driver for two players' BCD scores.
// Each frame it snapshots the digits, scans one digit per slot, and blinks a player's digits after that player's score changes.
module score_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] player1_score_unit,
  input  logic [3:0] player1_score_tens,
  input  logic [3:0] player2_score_unit,
  input  logic [3:0] player2_score_tens,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] prescaler_reg;
  logic [1:0]    idx_reg;
  logic [7:0]    frame_reg;
  logic [3:0]    snap_reg [4];
  logic          tick_d_reg;
  logic          tick;
  logic          wrap;
  logic [3:0]    digits [4];
  logic [1:0]    blank;

  // Digit index matches the slot index: 0=P2 units, 1=P2 tens, 2=P1 units, 3=P1 tens.
  assign digits[0] = player2_score_unit;
  assign digits[1] = player2_score_tens;
  assign digits[2] = player1_score_unit;
  assign digits[3] = player1_score_tens;

  assign tick = (prescaler_reg == PW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_reg <= '0;
      idx_reg       <= 2'd3;
      frame_reg     <= 8'd0;
      tick_d_reg    <= 1'b0;
      for (int i = 0; i < 4; i++) snap_reg[i] <= 4'd0;
    end else begin
      prescaler_reg <= tick ? '0 : prescaler_reg + PW'(1);
      tick_d_reg    <= tick;
      if (tick) idx_reg <= idx_reg + 2'd1;
      if (wrap) begin
        frame_reg <= frame_reg + 8'd1;
        for (int i = 0; i < 4; i++) snap_reg[i] <= digits[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [7:0] blink_reg;
      logic       changed;

      // Compared against the outgoing snapshot, so a change restarts the blink even mid-blink.
      assign changed = {digits[2*gi+1], digits[2*gi]} != {snap_reg[2*gi+1], snap_reg[2*gi]};

      always_ff @(posedge clk) begin
        if (reset) begin
          blink_reg <= 8'd0;
        end else if (wrap) begin
          if (changed)
            blink_reg <= 8'(BLINK_FRAMES);
          else if (blink_reg != 8'd0)
            blink_reg <= blink_reg - 8'd1;
        end
      end

      assign blank[gi] = (blink_reg != 8'd0) && frame_reg[0];
    end
  endgenerate

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  always_comb begin
    cur_digit = snap_reg[idx_reg];
    cur_blank = blank[idx_reg[1]];
    an_next   = 4'b1111;
    an_next[idx_reg] = 1'b0;
    seg_next  = decode(cur_digit);
    // Odd slots hold tens digits, which suppress a leading zero.
    if (cur_blank || (idx_reg[0] && (cur_digit == 4'd0)))
      seg_next = 7'b1111111;
    dp_next   = !((idx_reg == 2'd2) && !cur_blank);
  end

  // Output stage follows the tick by one cycle; stays blank until the first tick after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (tick_d_reg) begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: frame-level behavioural model checked every cycle,
// plus hand-computed literal expectations at chosen points.
module tb_score_display;
  localparam int DIV = 4;
  localparam int BF  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] p1u, p1t, p2u, p2t;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  score_display #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk),
    .reset(reset),
    .player1_score_unit(p1u),
    .player1_score_tens(p1t),
    .player2_score_unit(p2u),
    .player2_score_tens(p2t),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [6:0] ref_dec(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model state: cycles since reset, ticks seen, frames, captured digits, blink frames left.
  int   cnt, ticks, frame, slot, pl, dig;
  int   m_snap [4];
  int   m_cur [4];
  int   m_blink [2];
  logic bl;
  bit   armed = 0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clk) begin
    if (reset) begin
      cnt = 0; ticks = 0; frame = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 0;
      m_blink[0] = 0; m_blink[1] = 0;
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      armed = 1;
    end else begin
      if (ticks == 0) begin
        exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      end else begin
        slot = (ticks - 1) % 4;
        pl   = slot / 2;
        dig  = m_snap[slot];
        bl   = (m_blink[pl] != 0) && (frame % 2 == 1);
        exp_an = 4'b1111;
        exp_an[slot] = 1'b0;
        if (bl || (slot % 2 == 1 && dig == 0)) exp_seg = 7'b1111111;
        else exp_seg = ref_dec(dig);
        exp_dp = !(slot == 2 && !bl);
      end
      cnt++;
      if (cnt % DIV == 0) begin
        ticks++;
        if (ticks % 4 == 1) begin
          frame = (frame + 1) % 256;
          m_cur[0] = int'(p2u); m_cur[1] = int'(p2t);
          m_cur[2] = int'(p1u); m_cur[3] = int'(p1t);
          for (int p = 0; p < 2; p++) begin
            if (m_cur[2*p] != m_snap[2*p] || m_cur[2*p+1] != m_snap[2*p+1]) m_blink[p] = BF;
            else if (m_blink[p] > 0) m_blink[p]--;
          end
          for (int i = 0; i < 4; i++) m_snap[i] = m_cur[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      tests++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        fails++;
        $display("FAIL cycle_model t=%0t got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 $time, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  end

  task automatic check_lit(input string name, input logic [3:0] w_an, input logic [6:0] w_seg, input logic w_dp);
    tests++;
    if ({an, seg, dp} !== {w_an, w_seg, w_dp}) begin
      fails++;
      $display("FAIL %s got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               name, an, seg, dp, w_an, w_seg, w_dp);
    end else
      $display("[TB] %s an=%b seg=%b dp=%b ok", name, an, seg, dp);
  endtask

  task automatic wait_an(input logic [3:0] v);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an == v) begin found = 1; break; end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL wait_an timeout got an=%b want an=%b", an, v);
    end
  endtask

  initial begin
    p1t = 4'd0; p1u = 4'd7; p2t = 4'd1; p2u = 4'd2;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // First tick at cycle 4 loads digits that differ from the zero snapshot, so frame 1 is blanked.
    repeat (4) @(negedge clk);
    check_lit("reset_hold",     4'b1111, 7'b1111111, 1'b1);
    repeat (1) @(negedge clk);
    check_lit("first_slot_odd", 4'b1110, 7'b1111111, 1'b1);
    repeat (16) @(negedge clk);
    check_lit("p2_units_2",     4'b1110, 7'b0100100, 1'b1);
    repeat (4) @(negedge clk);
    check_lit("p2_tens_1",      4'b1101, 7'b1111001, 1'b1);
    repeat (4) @(negedge clk);
    check_lit("p1_units_7_dp",  4'b1011, 7'b1111000, 1'b0);
    repeat (4) @(negedge clk);
    check_lit("p1_tens_lz",     4'b0111, 7'b1111111, 1'b1);

    // Mid-frame change of P1 units.
    repeat (8) @(negedge clk);
    p1u = 4'd5;
    repeat (64) @(negedge clk);

    // P2 units change, run past the blink.
    p2u = 4'd3;
    repeat (96) @(negedge clk);

    // Both change, then P1 changes again during its blink.
    p1u = 4'd6; p2u = 4'd4;
    repeat (32) @(negedge clk);
    p1u = 4'd8;
    repeat (96) @(negedge clk);

    // Dash on P2 tens, leading-zero P1 tens.
    p2t = 4'hC; p1t = 4'd0;
    repeat (96) @(negedge clk);
    wait_an(4'b1101);
    check_lit("p2_tens_dash",   4'b1101, 7'b0111111, 1'b1);
    wait_an(4'b0111);
    check_lit("p1_tens_blank",  4'b0111, 7'b1111111, 1'b1);
    wait_an(4'b1011);
    check_lit("p1_units_8",     4'b1011, 7'b0000000, 1'b0);

    // Reset pulse during an active blink in slot 2.
    p1u = 4'd9;
    repeat (20) @(negedge clk);
    wait_an(4'b1011);
    reset = 1'b1;
    @(negedge clk);
    check_lit("reset_mid_blink", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0;
    repeat (128) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
